// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the MIPS multiply/divide unit.
//   - op codes carried on the unit's op input
//   - FSM state encoding
//   - MIPS SPECIAL func codes and a func -> op decode helper
//   - latched per-operation flags
package muldiv_pkg;

    // Operation codes presented on op with start.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NONE  = 3'd7;   // ignored by the unit

    // FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // MIPS SPECIAL-opcode func field values.
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    // Flags captured when an operation is accepted and consumed in FIX.
    typedef struct packed {
        logic is_div;    // divide datapath selected
        logic neg_q;     // negate product (multiply) or quotient (divide)
        logic neg_r;     // remainder takes a negative dividend's sign
        logic div_zero;  // divisor was zero: quotient forced to all ones
    } mdu_flags_t;

    // Decode: MFHI/MFLO read HI/LO directly and never start the unit,
    // so they map to OP_NONE along with every non-MDU func.
    function automatic logic [2:0] func_to_op(input logic [5:0] func);
        case (func)
            FUNC_MULT:  return OP_MULT;
            FUNC_MULTU: return OP_MULTU;
            FUNC_DIV:   return OP_DIV;
            FUNC_DIVU:  return OP_DIVU;
            FUNC_MTHI:  return OP_MTHI;
            FUNC_MTLO:  return OP_MTLO;
            default:    return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue-stage <-> multiply/divide unit handshake.
//   master (issue stage): drives start, op, rs_data, rt_data, cancel;
//                         observes busy, done, hi, lo.
//   slave  (muldiv_unit): the reverse.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative multiplier or
// divider, selected by is_div.
//   is_div   in  1        0: shift-add multiply, 1: restoring divide
//   acc      in  2*WIDTH  multiply: {partial product, remaining multiplier}
//                         divide:   {remainder, remaining dividend/quotient}
//   operand  in  WIDTH    multiplicand or divisor (magnitude)
//   acc_next out 2*WIDTH  accumulator after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // Multiply: add the multiplicand when the multiplier LSB is set,
        // then shift the whole {carry, acc} right one place.
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

        // Divide: bring the next dividend bit into the remainder and try
        // the subtract one bit wider, so the top bit is the borrow.
        shifted = acc[2*WIDTH-1:WIDTH-1];
        trial   = shifted - {1'b0, operand};

        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and
// MTHI/MTLO writes, under a start/busy/done handshake.
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of muldiv_if (start, op, rs_data, rt_data,
//            cancel in; busy, done, hi, lo out)
// Optional feature: define MULDIV_EARLY_OUT_EN to skip the iterations when a
// multiply operand is zero or a divisor is zero (IDLE goes straight to FIX).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset_n,
    muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    mdu_flags_t         flags_reg, flags_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    // Operand preparation at accept time.
    logic               is_mdu_op, is_div_op, is_signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    // Result formatting in FIX.
    logic [2*WIDTH-1:0] prod, acc_step;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (flags_reg.is_div),
        .acc      (acc_reg),
        .operand  (b_reg),
        .acc_next (acc_step)
    );

    always_comb begin
        is_mdu_op    = (bus.op[2] == 1'b0);
        is_div_op    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg        = is_signed_op & bus.rs_data[WIDTH-1];
        b_neg        = is_signed_op & bus.rt_data[WIDTH-1];
        a_mag        = a_neg ? -bus.rs_data : bus.rs_data;
        b_mag        = b_neg ? -bus.rt_data : bus.rt_data;

        prod   = flags_reg.neg_q ? -acc_reg : acc_reg;
        quo    = flags_reg.neg_q ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem    = flags_reg.neg_r ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        // With a zero divisor every trial subtract succeeds, so the
        // remainder already equals the dividend; only LO needs forcing.
        if (flags_reg.div_zero) begin
            quo = '1;
        end
        res_hi = flags_reg.is_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = flags_reg.is_div ? quo : prod[WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        b_next     = b_reg;
        flags_next = flags_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A flush in the same cycle suppresses any request.
                if (bus.start && !bus.cancel) begin
                    if (is_mdu_op) begin
                        flags_next.is_div   = is_div_op;
                        flags_next.neg_q    = a_neg ^ b_neg;
                        flags_next.neg_r    = is_div_op & a_neg;
                        flags_next.div_zero = is_div_op && (bus.rt_data == '0);
                        // Multiply: rt is the shifted multiplier, rs is added.
                        // Divide: rs is shifted through, rt is subtracted.
                        acc_next   = {{WIDTH{1'b0}}, is_div_op ? a_mag : b_mag};
                        b_next     = is_div_op ? b_mag : a_mag;
                        cnt_next   = '0;
                        busy_next  = 1'b1;
                        state_next = ST_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                        // Preload what the full iteration would have left.
                        if (is_div_op && (bus.rt_data == '0)) begin
                            acc_next   = {a_mag, {WIDTH{1'b0}}};
                            state_next = ST_FIX;
                        end else if (!is_div_op &&
                                     ((bus.rs_data == '0) || (bus.rt_data == '0))) begin
                            acc_next   = '0;
                            state_next = ST_FIX;
                        end
`endif
                    end else if (bus.op == OP_MTHI) begin
                        hi_next = bus.rs_data;
                    end else if (bus.op == OP_MTLO) begin
                        lo_next = bus.rs_data;
                    end
                end
            end

            ST_RUN: begin
                if (bus.cancel) begin
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    acc_next = acc_step;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
                if (!bus.cancel) begin
                    hi_next   = res_hi;
                    lo_next   = res_lo;
                    done_next = 1'b1;
                end
            end

            default: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            b_reg     <= '0;
            flags_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            b_reg     <= b_next;
            flags_reg <= flags_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: table of directed MDU operations plus
// hand-written sequences for MTHI/MTLO, ignored starts, cancel,
// back-to-back issue and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int FULL_EDGE = W + 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Edge (counted from the accepting edge 0) after which done is high.
    function automatic int exp_done_edge(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if ((op == OP_MULT || op == OP_MULTU) && (a == 0 || b == 0)) return 1;
        if ((op == OP_DIV || op == OP_DIVU) && b == 0) return 1;
`endif
        return FULL_EDGE;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int done_edge, output logic busy_seen);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        busy_seen = bus.busy;
        done_edge = 0;
        while (bus.done !== 1'b1 && done_edge < 100) begin
            @(posedge clock);
            @(negedge clock);
            done_edge++;
        end
    endtask

    // One-cycle MTHI/MTLO (or any single-cycle request) from a negedge.
    task automatic pulse_start(input logic [2:0] op, input logic [31:0] a, input logic cancel);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = 32'd0;
        bus.start   = 1'b1;
        bus.cancel  = cancel;
        @(posedge clock);
        @(negedge clock);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    initial begin
        int          de;
        logic        bs;
        int          dones;
        logic [31:0] cap_hi, cap_lo;

        bus.start   = 1'b0;
        bus.cancel  = 1'b0;
        bus.op      = 3'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{OP_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[6]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{OP_MULT,  32'h00000000, 32'h00003039, 32'h00000000, 32'h00000000};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[10] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        // Reset state while reset_n is held low.
        #12;
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // MTLO / MTHI: visible next cycle, no done, never busy.
        pulse_start(OP_MTLO, 32'h00001234, 1'b0);
        $display("MTLO rs=%h -> lo=%h done=%0d", 32'h1234, bus.lo, bus.done);
        check("mtlo_lo", bus.lo, 32'h00001234);
        check("mtlo_done", 32'(bus.done), 32'd0);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        pulse_start(OP_MTHI, 32'h0000ABCD, 1'b0);
        $display("MTHI rs=%h -> hi=%h done=%0d", 32'hABCD, bus.hi, bus.done);
        check("mthi_hi", bus.hi, 32'h0000ABCD);
        check("mthi_lo_kept", bus.lo, 32'h00001234);

        // Unknown op codes are ignored.
        pulse_start(3'd6, 32'h0BAD0BAD, 1'b0);
        pulse_start(3'd7, 32'h0BAD0BAD, 1'b0);
        $display("OP6/OP7 -> busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        check("unk_busy", 32'(bus.busy), 32'd0);
        check("unk_hi", bus.hi, 32'h0000ABCD);
        check("unk_lo", bus.lo, 32'h00001234);

        // cancel together with start in IDLE: the request is dropped.
        pulse_start(OP_MULT, 32'h00000006, 1'b1);
        check("cancel_start_busy", 32'(bus.busy), 32'd0);
        pulse_start(OP_MTLO, 32'h00005555, 1'b1);
        $display("start+cancel -> busy=%0d lo=%h", bus.busy, bus.lo);
        check("cancel_start_lo", bus.lo, 32'h00001234);

        // Table of full operations.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, de, bs);
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h done_edge=%0d",
                     vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, de);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
            check($sformatf("v%0d_done_edge", i), 32'(de),
                  32'(exp_done_edge(vecs[i].op, vecs[i].a, vecs[i].b)));
            check($sformatf("v%0d_busy_start", i), 32'(bs), 32'd1);
            check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
            @(posedge clock);
            @(negedge clock);
            check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // start raised 5 cycles into a MULT is ignored.
        bus.op = OP_MULT; bus.rs_data = 32'd6; bus.rt_data = 32'd7; bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        bus.op = OP_MULTU; bus.rs_data = 32'd9; bus.rt_data = 32'd9; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        dones = 0; cap_hi = 32'hDEADBEEF; cap_lo = 32'hDEADBEEF;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                dones++;
                cap_hi = bus.hi;
                cap_lo = bus.lo;
            end
        end
        $display("MULT 6*7 with late start -> dones=%0d hi=%h lo=%h", dones, cap_hi, cap_lo);
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_hi", cap_hi, 32'd0);
        check("busy_start_lo", cap_lo, 32'd42);
        check("busy_start_idle", 32'(bus.busy), 32'd0);

        // cancel 10 cycles into a DIVU.
        pulse_start(OP_MTHI, 32'h00001111, 1'b0);
        pulse_start(OP_MTLO, 32'h00002222, 1'b0);
        bus.op = OP_DIVU; bus.rs_data = 32'd1000; bus.rt_data = 32'd3; bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        bus.cancel = 1'b1;
        @(negedge clock);
        bus.cancel = 1'b0;
        check("cancel_busy", 32'(bus.busy), 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1) dones++;
        end
        $display("DIVU cancelled -> dones=%0d hi=%h lo=%h", dones, bus.hi, bus.lo);
        check("cancel_dones", 32'(dones), 32'd0);
        check("cancel_hi", bus.hi, 32'h00001111);
        check("cancel_lo", bus.lo, 32'h00002222);

        // Back-to-back: second op issued in the done cycle of the first.
        run_op(OP_MULTU, 32'd2, 32'd3, de, bs);
        $display("MULTU 2*3 -> hi=%h lo=%h done_edge=%0d", bus.hi, bus.lo, de);
        check("b2b_first_lo", bus.lo, 32'd6);
        check("b2b_first_done", 32'(bus.done), 32'd1);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd4, de, bs);
        $display("MULT -3*4 (back-to-back) -> hi=%h lo=%h done_edge=%0d", bus.hi, bus.lo, de);
        check("b2b_busy", 32'(bs), 32'd1);
        check("b2b_edge", 32'(de), 32'(FULL_EDGE));
        check("b2b_hi", bus.hi, 32'hFFFFFFFF);
        check("b2b_lo", bus.lo, 32'hFFFFFFF4);

        // Asynchronous reset mid-RUN.
        bus.op = OP_MULT; bus.rs_data = 32'd5; bus.rt_data = 32'd5; bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (8) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        $display("reset mid-RUN -> hi=%h lo=%h busy=%0d done=%0d", bus.hi, bus.lo, bus.busy, bus.done);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op(OP_MULTU, 32'd3, 32'd5, de, bs);
        $display("MULTU 3*5 after reset -> hi=%h lo=%h done_edge=%0d", bus.hi, bus.lo, de);
        check("post_rst_hi", bus.hi, 32'd0);
        check("post_rst_lo", bus.lo, 32'd15);
        check("post_rst_edge", 32'(de), 32'(FULL_EDGE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
